// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle MIPS-subset core
// sharing one memory port for fetch and data.
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              dbg_we,
  output logic [4:0]        dbg_waddr,
  output logic [31:0]       dbg_wdata
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] target;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sx;
  logic [31:0] j_addr;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};
  assign j_addr = {pc[31:28], ir[25:0], 2'b00};

  logic is_halt;
  logic is_r;
  logic is_j;
  logic is_beq;
  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_exec;

  // Instruction class decode; the halt opcode masks all others.
  always_comb begin
    is_halt = (op == HALT_OP);
    is_r    = 1'b0;
    if (!is_halt && op == OP_RTYPE) begin
      case (funct)
        FN_SLL, FN_ADD, FN_SUB,
        FN_AND, FN_OR, FN_SLT: is_r = 1'b1;
        default:               is_r = 1'b0;
      endcase
    end
    is_j    = !is_halt && (op == OP_J);
    is_beq  = !is_halt && (op == OP_BEQ);
    is_addi = !is_halt && (op == OP_ADDI);
    is_lw   = !is_halt && (op == OP_LW);
    is_sw   = !is_halt && (op == OP_SW);
    is_exec = is_r | is_beq | is_addi
            | is_lw | is_sw;
  end

  logic [31:0] alu_res;

  // ALU for R-type and addi results.
  always_comb begin
    alu_res = a + b;
    if (is_addi) begin
      alu_res = a + imm_sx;
    end else begin
      case (funct)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = {31'd0,
                   $signed(a) < $signed(b)};
        FN_SLL:  alu_res = b << shamt;
        default: alu_res = a + b;
      endcase
    end
  end

  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] addr_full;

  assign wb_addr   = is_r ? rd : rt;
  assign wb_data   = is_lw ? mdr : alu_out;
  assign addr_full = (state == MEM) ? alu_out : pc;

  assign mem_req   = rst_n
                   && (state == FETCH
                    || state == MEM);
  assign mem_we    = (state == MEM) && is_sw;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b;

  // Control FSM with datapath registers and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      target    <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      halted    <= 1'b0;
      dbg_we    <= 1'b0;
      dbg_waddr <= '0;
      dbg_wdata <= '0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      dbg_we <= 1'b0;
      unique case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a      <= rf[rs];
          b      <= rf[rt];
          target <= pc + {imm_sx[29:0], 2'b00};
          unique case (1'b1)
            is_halt: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            is_j: begin
              pc    <= j_addr;
              state <= FETCH;
            end
            is_exec: state <= EXEC;
            default: state <= FETCH;
          endcase
        end
        EXEC: begin
          unique case (1'b1)
            is_r | is_addi: begin
              alu_out   <= alu_res;
              dbg_we    <= 1'b1;
              dbg_waddr <= wb_addr;
              dbg_wdata <= alu_res;
              state     <= WB;
            end
            is_lw | is_sw: begin
              alu_out <= a + imm_sx;
              state   <= MEM;
            end
            is_beq: begin
              if (a == b) begin
                pc <= target;
              end
              state <= FETCH;
            end
            default: state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (is_sw) begin
              state <= FETCH;
            end else begin
              mdr       <= mem_rdata;
              dbg_we    <= 1'b1;
              dbg_waddr <= rt;
              dbg_wdata <= mem_rdata;
              state     <= WB;
            end
          end
        end
        WB: begin
          if (wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
          end
          state <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs plus random
// programs checked against an ISA-level model.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b1;
  logic [31:0] pc;
  logic        halted;
  logic        dbg_we;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;

  cpu_multicycle dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .halted    (halted),
    .dbg_we    (dbg_we),
    .dbg_waddr (dbg_waddr),
    .dbg_wdata (dbg_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int st_lo = 0;
  int st_hi = 0;
  bit sb_en = 0;

  logic        h_req  [1024];
  logic        h_we   [1024];
  logic [31:0] h_addr [1024];
  logic [31:0] h_wd   [1024];
  logic [31:0] h_pc   [1024];
  logic        h_halt [1024];
  logic        h_dwe  [1024];
  logic [4:0]  h_dwa  [1024];
  logic [31:0] h_dwd  [1024];

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q [$];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_pc;
  bit          m_halt;

  function automatic logic [31:0] sx(
    input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [25:0] t);
    return {6'h02, t};
  endfunction

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  task automatic chk(input string nm,
    input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
        nm, got, exp);
    end
  endtask

  task automatic push(input int k,
    input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.k = k;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic m_wr(input logic [4:0] r,
    input logic [31:0] v);
    push(2, {27'd0, r}, v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // One whole instruction at ISA level.
  task automatic model_step();
    logic [31:0] ir, x, y, r, ea;
    logic [4:0]  rs, rt, rd;
    bit          ok;
    ir = m_mem[m_pc[11:2]];
    push(0, m_pc, 32'd0);
    m_pc = m_pc + 32'd4;
    rs = ir[25:21];
    rt = ir[20:16];
    rd = ir[15:11];
    x  = m_reg[rs];
    y  = m_reg[rt];
    ea = x + sx(ir[15:0]);
    case (ir[31:26])
      6'h00: begin
        ok = 1;
        r  = 0;
        case (ir[5:0])
          6'h20: r = x + y;
          6'h22: r = x - y;
          6'h24: r = x & y;
          6'h25: r = x | y;
          6'h2A: r = ($signed(x) < $signed(y))
                     ? 32'd1 : 32'd0;
          6'h00: r = y << ir[10:6];
          default: ok = 0;
        endcase
        if (ok) m_wr(rd, r);
      end
      6'h08: m_wr(rt, ea);
      6'h23: begin
        push(0, ea, 32'd0);
        m_wr(rt, m_mem[ea[11:2]]);
      end
      6'h2B: begin
        push(1, ea, y);
        m_mem[ea[11:2]] = y;
      end
      6'h04: if (x == y)
        m_pc = m_pc + (sx(ir[15:0]) << 2);
      6'h02: m_pc = {m_pc[31:28], ir[25:0], 2'b00};
      6'h3F: m_halt = 1;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    for (int i = 0; i < 1024; i++)
      m_mem[i] = mem[i];
    m_pc   = 32'h0;
    m_halt = 0;
    exp_q.delete();
  endtask

  task automatic sb_see(input int k,
    input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0 && !m_halt) model_step();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_extra kind %0d addr %h data %h, none expected",
        k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.a !== a
          || (k != 0 && e.d !== d)) begin
        errors++;
        $display("FAIL sb_event got kind %0d addr %h data %h expected kind %0d addr %h data %h",
          k, a, d, e.k, e.a, e.d);
      end
    end
  endtask

  // Per-cycle monitor: history, memory writes, scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc++;
      if (cyc < 1024) begin
        h_req[cyc]  = mem_req;
        h_we[cyc]   = mem_we;
        h_addr[cyc] = mem_addr;
        h_wd[cyc]   = mem_wdata;
        h_pc[cyc]   = pc;
        h_halt[cyc] = halted;
        h_dwe[cyc]  = dbg_we;
        h_dwa[cyc]  = dbg_waddr;
        h_dwd[cyc]  = dbg_wdata;
      end
      if (mem_req && mem_ready && mem_we)
        mem[mem_addr[11:2]] = mem_wdata;
      if (sb_en) begin
        if (mem_req && mem_ready)
          sb_see(mem_we ? 1 : 0, mem_addr, mem_wdata);
        if (dbg_we)
          sb_see(2, {27'd0, dbg_waddr}, dbg_wdata);
      end
    end
  end

  // Memory ready driver for the upcoming cycle.
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      1: mem_ready = ($urandom_range(0, 3) != 0);
      2: mem_ready = !((cyc + 1) >= st_lo
                    && (cyc + 1) <= st_hi);
      default: mem_ready = 1'b1;
    endcase
  end

  initial begin
    #3000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  task automatic reset_hold();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_en = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) mem[i] = 0;
  endtask

  task automatic release_rst();
    model_reset();
    sb_en = 1;
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int maxc);
    int n = 0;
    while (!halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic gen_prog(input int n);
    logic [5:0]  fns [6];
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] dofs;
    int          sel, lim, k;
    fns = '{6'h20, 6'h22, 6'h24,
            6'h25, 6'h2A, 6'h00};
    for (int i = 0; i < n; i++) begin
      sel  = $urandom_range(0, 11);
      lim  = (n - 1 - i) < 3 ? (n - 1 - i) : 3;
      k    = $urandom_range(0, lim);
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 7));
      sh   = 5'($urandom_range(0, 31));
      dofs = 16'(32'h400 + 4 * $urandom_range(0, 63));
      case (sel)
        0, 1, 2, 3, 4, 5:
          mem[i] = enc_r(rs, rt, rd,
            fns[sel] == 6'h00 ? sh : 5'd0, fns[sel]);
        6: mem[i] = enc_i(6'h08, rs, rt,
             16'($urandom));
        7: mem[i] = enc_i(6'h23, 5'd0, rt, dofs);
        8: mem[i] = enc_i(6'h2B, 5'd0, rt, dofs);
        9: mem[i] = enc_i(6'h04, rs, rt, 16'(k));
        10: mem[i] = enc_j(26'(i + 1 + k));
        default:
          mem[i] = $urandom_range(0, 1) != 0
            ? enc_r(rs, rt, rd, 5'd0, 6'h21)
            : {6'h10, 26'($urandom)};
      endcase
    end
    mem[n] = HALT_I;
    for (int i = 256; i < 320; i++) mem[i] = $urandom;
  endtask

  initial begin
    logic [31:0] pc0;
    int          viol;
    int          n;

    // Arithmetic chain, store/load, r0 write, halt.
    reset_hold();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_dbg", dbg_we, 0);
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    mem[3]  = enc_j(26'h10);
    mem[16] = enc_i(6'h2B, 5'd0, 5'd3, 16'h10);
    mem[17] = enc_i(6'h23, 5'd0, 5'd4, 16'h10);
    mem[18] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    mem[19] = enc_i(6'h08, 5'd0, 5'd5, 16'd0);
    mem[20] = HALT_I;
    rmode = 0;
    release_rst();
    wait_halt(200);
    chk("t1_fetch1", {h_req[1], h_we[1], h_addr[1]},
      {1'b1, 1'b0, 32'h0});
    chk("t1_dbg4", {h_dwe[4], h_dwa[4], h_dwd[4]},
      {1'b1, 5'd1, 32'd5});
    chk("t1_pulse5", h_dwe[5], 0);
    chk("t1_dbg8", {h_dwe[8], h_dwa[8], h_dwd[8]},
      {1'b1, 5'd2, 32'd7});
    chk("t1_dbg12", {h_dwe[12], h_dwa[12], h_dwd[12]},
      {1'b1, 5'd3, 32'd12});
    chk("t1_sw18", {h_req[18], h_we[18], h_addr[18],
      h_wd[18]}, {1'b1, 1'b1, 32'h10, 32'd12});
    chk("t1_dbg23", {h_dwe[23], h_dwa[23], h_dwd[23]},
      {1'b1, 5'd4, 32'd12});
    chk("t1_dbg27_r0", {h_dwe[27], h_dwa[27], h_dwd[27]},
      {1'b1, 5'd0, 32'd9});
    chk("t1_dbg31_r0reads0",
      {h_dwe[31], h_dwa[31], h_dwd[31]},
      {1'b1, 5'd5, 32'd0});
    chk("t1_halt33", h_halt[33], 0);
    chk("t1_halt34", h_halt[34], 1);
    pc0  = pc;
    viol = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_req || pc !== pc0 || !halted) viol++;
    end
    chk("t1_halt_pc", pc0, 32'h54);
    chk("t1_halt_frozen", viol, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // Taken beq looping on itself at 0x20.
    reset_hold();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    mem[1] = enc_j(26'h8);
    mem[8] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    release_rst();
    repeat (20) @(negedge clk);
    chk("t2_fetch7", {h_req[7], h_addr[7], h_pc[7]},
      {1'b1, 32'h20, 32'h20});
    chk("t2_pc8", h_pc[8], 32'h24);
    chk("t2_fetch10", {h_req[10], h_addr[10], h_pc[10]},
      {1'b1, 32'h20, 32'h20});
    chk("t2_fetch13", {h_req[13], h_addr[13]},
      {1'b1, 32'h20});

    // Not-taken beq falls through to 0x24.
    reset_hold();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd4);
    mem[2] = enc_j(26'h8);
    mem[8] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    mem[9] = HALT_I;
    release_rst();
    wait_halt(100);
    chk("t3_noreq12_13", {h_req[12], h_req[13]}, 0);
    chk("t3_fetch14", {h_req[14], h_addr[14], h_pc[14]},
      {1'b1, 32'h24, 32'h24});
    chk("t3_q_empty", exp_q.size(), 0);

    // Load with three wait cycles in MEM.
    reset_hold();
    mem[0]  = enc_i(6'h23, 5'd0, 5'd6, 16'h100);
    mem[1]  = HALT_I;
    mem[64] = 32'hDEAD_BEEF;
    rmode = 2;
    st_lo = 4;
    st_hi = 6;
    release_rst();
    wait_halt(100);
    for (int c = 4; c <= 7; c++)
      chk($sformatf("t4_stall_c%0d", c),
        {h_req[c], h_we[c], h_addr[c]},
        {1'b1, 1'b0, 32'h100});
    chk("t4_nodbg7", h_dwe[7], 0);
    chk("t4_dbg8", {h_dwe[8], h_dwa[8], h_dwd[8]},
      {1'b1, 5'd6, 32'hDEAD_BEEF});
    chk("t4_next9", {h_req[9], h_addr[9]},
      {1'b1, 32'h4});

    // Reset during a stalled load read.
    reset_hold();
    mem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h104);
    mem[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[2] = enc_i(6'h23, 5'd0, 5'd7, 16'h100);
    mem[3] = HALT_I;
    rmode = 2;
    st_lo = 12;
    st_hi = 100000;
    release_rst();
    n = 0;
    while (cyc < 14 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_stalled14", {h_req[14], h_addr[14]},
      {1'b1, 32'h100});
    chk("t5_dbg8", {h_dwe[8], h_dwa[8], h_dwd[8]},
      {1'b1, 5'd1, 32'd5});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_en = 0;
    @(posedge clk);
    #1;
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_dbg", {halted, dbg_we}, 0);
    rmode = 0;
    @(posedge clk);
    #1;
    release_rst();
    wait_halt(100);
    chk("t5_refetch1", {h_req[1], h_addr[1]},
      {1'b1, 32'h0});
    chk("t5_regs_cleared",
      {h_req[4], h_we[4], h_addr[4], h_wd[4]},
      {1'b1, 1'b1, 32'h104, 32'h0});

    // Random programs with random memory stalls.
    for (int t = 0; t < 3; t++) begin
      reset_hold();
      gen_prog(40);
      rmode = 1;
      release_rst();
      wait_halt(5000);
      repeat (4) @(negedge clk);
      chk($sformatf("rnd%0d_q_empty", t),
        exp_q.size(), 0);
      chk($sformatf("rnd%0d_pc", t), pc, m_pc);
      chk($sformatf("rnd%0d_mhalt", t), halted, m_halt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
